// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the writeback-side signals of wb_arbiter.
//   slave  modport : the arbiter's view (results in, register-file write out)
//   master modport : the view of the pipeline / mult-div-load unit / decode
interface wb_arbiter_if;
    // Port A: in-order pipeline result
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ovf_chk;
    logic        a_ovf;
    // Port B: multi-cycle unit result (valid/ready)
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    // Decode issue of a port-B op and pending-register scoreboard
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic [31:0] busy;
    // Register-file write port
    logic        regwrite;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;
    logic        overflow_flag;
    logic        of_control;
    logic        ovf_exc;

    modport slave (
        input  a_valid, a_reg, a_data, a_ovf_chk, a_ovf,
        input  b_valid, b_reg, b_data,
        input  iss_valid, iss_reg,
        output b_ready, busy,
        output regwrite, wrreg, wrdata, overflow_flag, of_control, ovf_exc
    );

    modport master (
        output a_valid, a_reg, a_data, a_ovf_chk, a_ovf,
        output b_valid, b_reg, b_data,
        output iss_valid, iss_reg,
        input  b_ready, busy,
        input  regwrite, wrreg, wrdata, overflow_flag, of_control, ovf_exc
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the in-order pipeline result (port A, top priority) and
// the multi-cycle unit result (port B, buffered in a DEPTH-entry FIFO) onto the
// single register-file write port, and tracks outstanding port-B destinations
// in a busy scoreboard for decode stalls.
// Optional macro WB_BYPASS_EN: a port-B result arriving while the FIFO is empty
// and port A is idle goes straight to the output flops (latency 1).
module wb_arbiter #(
    parameter int DEPTH = 4,   // FIFO entries, power of 2, >= 2
    parameter int PW    = 2    // log2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    // FIFO storage and control
    logic [4:0]    mem_reg_q  [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // Registered outputs
    logic          regwrite_q, regwrite_d;
    logic [4:0]    wrreg_q, wrreg_d;
    logic [31:0]   wrdata_q, wrdata_d;
    logic          overflow_flag_q, overflow_flag_d;
    logic          of_control_q, of_control_d;
    logic          ovf_exc_q, ovf_exc_d;
    logic [31:0]   busy_q, busy_d;

    // Handshake / selection
    logic          b_ready_s;
    logic          push_s;
    logic          pop_s;
    logic          bypass_s;
    logic          a_trap_s;
    logic [4:0]    head_reg_s;
    logic [31:0]   head_data_s;

    assign b_ready_s   = (count_q < FULL_CNT);
    assign head_reg_s  = mem_reg_q[rd_ptr_q];
    assign head_data_s = mem_data_q[rd_ptr_q];
    assign a_trap_s    = bus.a_ovf_chk & bus.a_ovf;

    // Bypass qualifier: direct B-to-output path only when nothing is queued or competing
    always_comb begin
`ifdef WB_BYPASS_EN
        bypass_s = (count_q == {(PW+1){1'b0}}) && !bus.a_valid && bus.b_valid;
`else
        bypass_s = 1'b0;
`endif
    end

    // FIFO push/pop decisions and pointer/count next state
    always_comb begin
        push_s   = bus.b_valid && b_ready_s && !bypass_s;
        pop_s    = !bus.a_valid && (count_q != {(PW+1){1'b0}});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port source selection: A, else FIFO head, else bypassed B, else idle
    always_comb begin
        regwrite_d      = 1'b0;
        wrreg_d         = wrreg_q;
        wrdata_d        = wrdata_q;
        overflow_flag_d = 1'b0;
        of_control_d    = 1'b0;
        ovf_exc_d       = 1'b0;
        if (bus.a_valid) begin
            wrreg_d         = bus.a_reg;
            wrdata_d        = bus.a_data;
            of_control_d    = bus.a_ovf_chk;
            overflow_flag_d = a_trap_s;
            ovf_exc_d       = a_trap_s;
            regwrite_d      = (bus.a_reg != 5'd0) && !a_trap_s;
        end else if (pop_s) begin
            wrreg_d    = head_reg_s;
            wrdata_d   = head_data_s;
            regwrite_d = (head_reg_s != 5'd0);
        end else if (bypass_s) begin
            wrreg_d    = bus.b_reg;
            wrdata_d   = bus.b_data;
            regwrite_d = (bus.b_reg != 5'd0);
        end else begin
            regwrite_d = 1'b0;
        end
    end

    // Busy scoreboard: retire clears first so a same-edge issue wins
    always_comb begin
        busy_d = busy_q;
        if (pop_s) begin
            busy_d[head_reg_s] = 1'b0;
        end else if (bypass_s) begin
            busy_d[bus.b_reg] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (bus.iss_valid && (bus.iss_reg != 5'd0)) begin
            busy_d[bus.iss_reg] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // FIFO storage: entry written at wr_ptr on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg_q[i]  <= 5'd0;
                mem_data_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            mem_reg_q[wr_ptr_q]  <= bus.b_reg;
            mem_data_q[wr_ptr_q] <= bus.b_data;
        end
    end

    // Control and output state registers; reset drops any queued entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= {PW{1'b0}};
            rd_ptr_q        <= {PW{1'b0}};
            count_q         <= {(PW+1){1'b0}};
            regwrite_q      <= 1'b0;
            wrreg_q         <= 5'd0;
            wrdata_q        <= 32'd0;
            overflow_flag_q <= 1'b0;
            of_control_q    <= 1'b0;
            ovf_exc_q       <= 1'b0;
            busy_q          <= 32'd0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            regwrite_q      <= regwrite_d;
            wrreg_q         <= wrreg_d;
            wrdata_q        <= wrdata_d;
            overflow_flag_q <= overflow_flag_d;
            of_control_q    <= of_control_d;
            ovf_exc_q       <= ovf_exc_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.b_ready       = b_ready_s;
    assign bus.busy          = busy_q;
    assign bus.regwrite      = regwrite_q;
    assign bus.wrreg         = wrreg_q;
    assign bus.wrdata        = wrdata_q;
    assign bus.overflow_flag = overflow_flag_q;
    assign bus.of_control    = of_control_q;
    assign bus.ovf_exc       = ovf_exc_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. Stimulus runs a queue-based
// reference model each cycle and pushes the expected post-edge outputs; an
// independent monitor pops and compares them one time unit after each edge.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH), .PW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  wrreg;
        logic [31:0] wrdata;
        logic        of_control;
        logic        overflow_flag;
        logic        ovf_exc;
        logic        b_ready;
        logic [31:0] busy;
    } rec_t;

    rec_t exp_q [$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    logic [4:0]  mq_reg  [$];
    logic [31:0] mq_data [$];
    logic [31:0] m_busy   = 32'd0;
    logic [4:0]  m_wrreg  = 5'd0;
    logic [31:0] m_wrdata = 32'd0;

    // Monitor: compare DUT outputs against the oldest expectation
    initial begin
        rec_t e;
        rec_t act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act.regwrite      = bus.regwrite;
                act.wrreg         = bus.wrreg;
                act.wrdata        = bus.wrdata;
                act.of_control    = bus.of_control;
                act.overflow_flag = bus.overflow_flag;
                act.ovf_exc       = bus.ovf_exc;
                act.b_ready       = bus.b_ready;
                act.busy          = bus.busy;
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL wb_out t=%0t got rw=%0b reg=%0d data=%h ofc=%0b ovf=%0b exc=%0b rdy=%0b busy=%h | want rw=%0b reg=%0d data=%h ofc=%0b ovf=%0b exc=%0b rdy=%0b busy=%h",
                             $time, act.regwrite, act.wrreg, act.wrdata, act.of_control,
                             act.overflow_flag, act.ovf_exc, act.b_ready, act.busy,
                             e.regwrite, e.wrreg, e.wrdata, e.of_control,
                             e.overflow_flag, e.ovf_exc, e.b_ready, e.busy);
                end
            end
        end
    end

    task automatic drive_idle();
        bus.a_valid = 1'b0; bus.a_reg = 5'd0; bus.a_data = 32'd0;
        bus.a_ovf_chk = 1'b0; bus.a_ovf = 1'b0;
        bus.b_valid = 1'b0; bus.b_reg = 5'd0; bus.b_data = 32'd0;
        bus.iss_valid = 1'b0; bus.iss_reg = 5'd0;
    endtask

    // Hold reset for n cycles; model empties and outputs read all-zero
    task automatic do_reset(input int n);
        rec_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            drive_idle();
            mq_reg.delete();
            mq_data.delete();
            m_busy = 32'd0; m_wrreg = 5'd0; m_wrdata = 32'd0;
            e = '0;
            e.b_ready = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // One cycle of stimulus plus the model's prediction for the next edge
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic ac, input logic ao,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic iv, input logic [4:0] ir);
        rec_t e;
        logic acc, byp, trap;
        logic [4:0] hr;
        logic [31:0] hd;
        @(negedge clk);
        rst = 1'b0;
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.a_ovf_chk = ac; bus.a_ovf = ao;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
        bus.iss_valid = iv; bus.iss_reg = ir;

        e = '0;
        e.wrreg  = m_wrreg;
        e.wrdata = m_wrdata;
        acc = bv && (mq_reg.size() < DEPTH);
        byp = 1'b0;
`ifdef WB_BYPASS_EN
        byp = (mq_reg.size() == 0) && !av && bv;
`endif
        if (av) begin
            trap = ac && ao;
            e.wrreg = ar; e.wrdata = ad;
            e.regwrite = (ar != 5'd0) && !trap;
            e.of_control = ac; e.overflow_flag = trap; e.ovf_exc = trap;
        end else if (mq_reg.size() > 0) begin
            hr = mq_reg.pop_front();
            hd = mq_data.pop_front();
            e.wrreg = hr; e.wrdata = hd;
            e.regwrite = (hr != 5'd0);
            m_busy[hr] = 1'b0;
        end else if (byp) begin
            e.wrreg = br; e.wrdata = bd;
            e.regwrite = (br != 5'd0);
            m_busy[br] = 1'b0;
        end
        if (acc && !byp) begin
            mq_reg.push_back(br);
            mq_data.push_back(bd);
        end
        if (iv && ir != 5'd0) m_busy[ir] = 1'b1;
        m_busy[0] = 1'b0;
        m_wrreg  = e.wrreg;
        m_wrdata = e.wrdata;
        e.busy    = m_busy;
        e.b_ready = (mq_reg.size() < DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        int pct;
        drive_idle();
        do_reset(3);

        // Plain A write, then trapping A op
        step(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step(1'b1, 5'd8, 32'hDEAD, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle(2);

        // A starves B while the FIFO fills; a fifth offer is refused; then drain
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(i + 1), 32'hA000 + i, 1'b0, 1'b0,
                 1'b1, 5'(9 + i), 32'hB000 + i, 1'b0, 5'd0);
        step(1'b1, 5'd2, 32'hA0FF, 1'b0, 1'b0, 1'b1, 5'd13, 32'hBBBB, 1'b0, 5'd0);
        idle(6);

        // Scoreboard: issue 17, retire 17 with a same-edge re-issue of 17
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd17);
        step(1'b1, 5'd3, 32'h3, 1'b0, 1'b0, 1'b1, 5'd17, 32'h1717, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd17);
        step(1'b1, 5'd4, 32'h4, 1'b0, 1'b0, 1'b1, 5'd17, 32'h2727, 1'b0, 5'd0);
        idle(3);

        // Register 0 from both ports, and an issue to 0
        step(1'b1, 5'd0, 32'h5555, 1'b0, 1'b0, 1'b1, 5'd0, 32'h6666, 1'b1, 5'd0);
        idle(3);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd6, 32'h60 + i, 1'b0, 1'b0,
                 1'b1, 5'(20 + i), 32'hC0 + i, 1'b1, 5'(20 + i));
        do_reset(2);
        idle(4);

        // Lone B result into an empty FIFO (bypass path when enabled)
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0);
        idle(3);

        // Randomized traffic in phases of heavy, balanced and light A load
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0:       pct = 90;
                1:       pct = 50;
                default: pct = 10;
            endcase
            step(($urandom_range(99) < pct), 5'($urandom), $urandom,
                 1'($urandom), 1'($urandom),
                 1'($urandom), 5'($urandom), $urandom,
                 ($urandom_range(3) == 0), 5'($urandom));
            if (i == 1500) do_reset(1);
        end
        idle(8);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side initiator for the 32x32 MIPS register file.
- Merges results from two sources into the register file's single write port (regwrite/wrreg/wrdata, plus overflow_flag/of_control):
  - the in-order pipeline (port A, highest priority, never stalled);
  - the multi-cycle mult/div/load unit (port B, valid/ready).
- Buffers port B results in a small FIFO.
- Keeps a pending-register scoreboard that decode uses for stalling.

Parameters:
DEPTH, 4, port-B FIFO entries; power of 2, minimum 2
PW, 2, FIFO pointer width; equals log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
a_valid  input  1  pipeline result valid this cycle
a_reg  input  5  pipeline destination register
a_data  input  32  pipeline result data
a_ovf_chk  input  1  result comes from a trapping op (add/addi/sub)
a_ovf  input  1  arithmetic overflow occurred
b_valid  input  1  mult/div/load result valid
b_ready  output  1  FIFO can accept a port-B result
b_reg  input  5  port-B destination register
b_data  input  32  port-B result data
iss_valid  input  1  decode issues a port-B op this cycle
iss_reg  input  5  destination register of the issued port-B op
busy  output  32  busy[r]=1 while a port-B write to r is outstanding
regwrite  output  1  register file write enable (registered)
wrreg  output  5  register file write address (registered)
wrdata  output  32  register file write data (registered)
overflow_flag  output  1  to register file (registered)
of_control  output  1  to register file (registered)
ovf_exc  output  1  one-cycle pulse: overflow trap, write suppressed

Behaviour:
- Reset (async, rst=1):
  - regwrite, wrreg, wrdata, overflow_flag, of_control, ovf_exc = 0;
  - busy = 0;
  - FIFO empty, rd/wr pointers and count = 0.
  - Reset mid-operation discards all queued port-B entries.
- All outputs except b_ready are flops updated on posedge clk.
- b_ready = (count < DEPTH), combinational from count only; no combinational path from b_valid.
- Push: b_valid && b_ready at edge → entry {b_reg, b_data} written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Output selection each edge, in priority order:
  1. a_valid=1:
     - wrreg=a_reg, wrdata=a_data, of_control=a_ovf_chk, overflow_flag=a_ovf_chk&a_ovf.
     - regwrite=1 unless a_reg==0 or (a_ovf_chk&&a_ovf).
     - ovf_exc=a_ovf_chk&a_ovf.
     - FIFO not popped.
  2. a_valid=0 and count>0: pop head; regwrite=(head.reg!=0), wrreg/wrdata from head, of_control=overflow_flag=0, ovf_exc=0; rd_ptr wraps.
  3. Otherwise: regwrite=0, of_control=0, overflow_flag=0, ovf_exc=0. wrreg and wrdata hold their previous values.
- Latency:
  - A: result visible on regwrite one cycle after a_valid.
  - B: minimum two edges, push edge then pop edge.
  - A starves B indefinitely while a_valid stays high; this is allowed.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. Push is legal only if count<DEPTH before the edge.
- Scoreboard:
  - iss_valid && iss_reg!=0 sets busy[iss_reg].
  - A port-B pop clears busy[head.reg].
  - Set and clear of the same register on one edge: set wins.
  - busy[0] is always 0.
- Decode guarantees no port-A write to a busy register. This block does not check for it.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - When count==0, a_valid=0 and b_valid=1, the B result goes straight to the output flops on the same edge (latency 1).
  - The FIFO is not written, and busy is cleared on that edge.
  - b_ready behaviour is unchanged.
- Undefined: every B result passes through the FIFO (minimum latency 2).

Test Plan:
- Reset, then a_valid=1, a_reg=5, a_data=0x1234 → next cycle regwrite=1, wrreg=5, wrdata=0x1234, of_control=0.
- a_valid=1, a_reg=8, a_ovf_chk=1, a_ovf=1 → regwrite=0, of_control=1, overflow_flag=1, ovf_exc one-cycle pulse.
- Hold a_valid=1 while pushing 4 B results (regs 9..12) → b_ready falls after the 4th push. Drop a_valid → regs 9,10,11,12 written in order on 4 consecutive cycles, then b_ready=1.
- iss_valid with iss_reg=17 → busy[17]=1. B result for reg 17 is popped → busy[17]=0 on the pop edge. Issue to reg 17 on that same edge → busy[17] stays 1.
- B writes to reg 0 and A writes to reg 0 → regwrite=0 in both cases; busy[0] stays 0.
- Assert rst while FIFO holds 3 entries → count=0, b_ready=1, busy=0, no further regwrite pulses. With WB_BYPASS_EN: empty FIFO and b_valid → regwrite one cycle later.
